regd: RTL and testbench

REGD -- requirements
Module: regd

---
 rtl/regd_if.sv | 56 +++++
 rtl/regd.sv | 56 +++++
 tb/tb_regd.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regd_if.sv
// Register-file bus interface.
//
// Groups everything except clock and reset for the regd register file.
//   regwrite : write enable
//   memtoreg : write-back source select (1 = wd, 0 = a)
//   a        : ALU-result write-back source
//   b        : reserved operand, ignored by the register file
//   ra1, ra2 : read addresses
//   wa       : write address, only wa[2:0] is decoded
//   wd       : memory-data write-back source
//   rd1, rd2 : read data
//   regDst   : selected write-back value
//
// The master modport belongs to the block that drives addresses and data.
// The slave modport belongs to the register file itself.
interface regd_if;
    logic       regwrite;
    logic       memtoreg;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [7:0] regDst;

    modport master (
        output regwrite,
        output memtoreg,
        output a,
        output b,
        output ra1,
        output ra2,
        output wa,
        output wd,
        input  rd1,
        input  rd2,
        input  regDst
    );

    modport slave (
        input  regwrite,
        input  memtoreg,
        input  a,
        input  b,
        input  ra1,
        input  ra2,
        input  wa,
        input  wd,
        output rd1,
        output rd2,
        output regDst
    );
endinterface

// File: rtl/regd.sv
// regd: 8 x 8-bit register file with a write-back source mux.
//
// Ports:
//   clk   : clock, all state changes on its rising edge
//   reset : synchronous active-high reset, clears every register
//   bus   : regd_if.slave carrying the write controls, addresses and data
//
// Behaviour:
//   - regDst is a purely combinational mux (wd when memtoreg, else a). Reset
//     and regwrite have no effect on it.
//   - On a rising edge, reset clears every register. Otherwise, when regwrite
//     is set, register wa[2:0] loads regDst.
//   - Reads are asynchronous and have no write bypass. A write becomes visible
//     only after the edge that performs it.
//   - r0 is an ordinary writable register.
module regd (
    input  logic   clk,
    input  logic   reset,
    regd_if.slave  bus
);
    localparam int unsigned NumRegs = 8;
    localparam int unsigned Width   = 8;

    logic [NumRegs-1:0][Width-1:0] regs_q, regs_d;
    logic [Width-1:0]              wb_data;
    logic [2:0]                    waddr;

    // b and the upper write-address bits are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{bus.b, bus.wa[7:3]};

    assign waddr   = bus.wa[2:0];
    assign wb_data = bus.memtoreg ? bus.wd : bus.a;

    always_comb begin
        regs_d = regs_q;
        if (bus.regwrite) begin
            regs_d[waddr] = wb_data;
        end
    end

    // Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads come straight from the stored state, never from regs_d.
    assign bus.rd1    = regs_q[bus.ra1];
    assign bus.rd2    = regs_q[bus.ra2];
    assign bus.regDst = wb_data;

endmodule

// File: tb/tb_regd.sv
// Self-checking bench for regd.
// Each expected value is pushed onto a scoreboard queue when the stimulus is
// applied. It is popped and compared when the DUT output is sampled.
module tb_regd;
    logic clk;
    logic reset;

    regd_if bus ();

    regd dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model [8];

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Read every register through both ports, with b toggling, against the model.
    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.ra1 = 3'(i);
            bus.ra2 = 3'(7 - i);
            bus.b   = (i % 2 == 0) ? 8'hFF : 8'h00;
            push($sformatf("%s_rd1_r%0d", tag, i), model[i]);
            push($sformatf("%s_rd2_r%0d", tag, 7 - i), model[7 - i]);
            settle();
            check(bus.rd1);
            check(bus.rd2);
        end
    endtask

    initial begin
        bus.regwrite = 1'b0;
        bus.memtoreg = 1'b0;
        bus.a        = 8'h3C;
        bus.b        = 8'h00;
        bus.ra1      = 3'd0;
        bus.ra2      = 3'd0;
        bus.wa       = 8'h00;
        bus.wd       = 8'h00;
        reset        = 1'b1;

        // regDst must follow the mux even while reset is held.
        push("regdst_in_reset", 8'h3C);
        settle();
        check(bus.regDst);

        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        sweep("after_reset");

        // memtoreg=1, wd=45 into r0: regDst is valid before the edge, but rd1 only changes after it.
        bus.memtoreg = 1'b1;
        bus.wd       = 8'd45;
        bus.wa       = 8'd0;
        bus.regwrite = 1'b1;
        bus.ra1      = 3'd0;
        push("regdst_wd45", 8'd45);
        push("rd1_before_edge", 8'h00);
        settle();
        check(bus.regDst);
        check(bus.rd1);
        tick();
        model[0] = 8'd45;
        bus.regwrite = 1'b0;
        push("rd1_after_edge", 8'd45);
        settle();
        check(bus.rd1);

        // memtoreg=0, a=0x5A, wa=0x0B: the upper address bits are ignored, so r3 is written.
        bus.memtoreg = 1'b0;
        bus.a        = 8'h5A;
        bus.wa       = 8'h0B;
        bus.regwrite = 1'b1;
        bus.ra2      = 3'd3;
        push("rd2_r3_before", 8'h00);
        settle();
        check(bus.rd2);
        tick();
        model[3] = 8'h5A;
        bus.regwrite = 1'b0;
        push("rd2_r3_after", 8'h5A);
        push("rd1_r0_kept", 8'd45);
        settle();
        check(bus.rd2);
        check(bus.rd1);

        // With regwrite=0, an edge changes nothing, and regDst shows wd.
        bus.memtoreg = 1'b1;
        bus.wd       = 8'hFF;
        bus.wa       = 8'd0;
        push("regdst_ff", 8'hFF);
        settle();
        check(bus.regDst);
        tick();
        sweep("no_write");

        // A write during reset is discarded.
        bus.regwrite = 1'b1;
        bus.wd       = 8'h77;
        bus.wa       = 8'd2;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        bus.regwrite = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        sweep("reset_over_write");

        // Write 0x11..0x88 to r0..r7 on successive edges, with junk in wa[7:3].
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.wa = {5'($urandom_range(0, 31)), 3'(i)};
            bus.wd = 8'((i + 1) * 8'h11);
            bus.b  = 8'($urandom);
            tick();
            model[i] = 8'((i + 1) * 8'h11);
        end
        bus.regwrite = 1'b0;
        sweep("fill");

        // Back-to-back writes to r5: only the last one is kept.
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b0;
        bus.wa       = 8'd5;
        bus.a = 8'hA1; tick();
        bus.a = 8'hA2; tick();
        bus.a = 8'hA3; tick();
        bus.regwrite = 1'b0;
        model[5] = 8'hA3;
        sweep("last_write");

        // When both ports address the same register, rd1 and rd2 are identical.
        for (int i = 0; i < 8; i++) begin
            bus.ra1 = 3'(i);
            bus.ra2 = 3'(i);
            push($sformatf("same_rd1_r%0d", i), model[i]);
            push($sformatf("same_rd2_r%0d", i), model[i]);
            settle();
            check(bus.rd1);
            check(bus.rd2);
        end

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
